// File: rtl/data_mem_responder.sv
// data_mem_responder: responder side of the CPU data-memory bus.
// Each accepted load/store is split into 1, 2 or 4 little-endian byte accesses
// on a byte-wide single-port BRAM with a fixed read latency. One request is in
// flight at a time, and busy_out marks that window.
//
// Handshake: a dispatch is sampled on a rising edge only while busy_out=0.
// Exactly one dispatch high with a legal width starts a request. An illegal
// dispatch produces a one-cycle err_out pulse. A dispatch while busy_out=1 is
// dropped without comment. A completed load is marked by a one-cycle
// data_valid_out pulse, with read_data_out valid in that same cycle.
module data_mem_responder #(
   parameter int ADDR_W     = 16,
   parameter int RD_LATENCY = 2
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic [31:0]       addr_in,
   input  logic [31:0]       write_data_in,
   input  logic [1:0]        mem_width_in,
   input  logic              dispatch_read_in,
   input  logic              dispatch_write_in,
   output logic              busy_out,
   output logic [31:0]       read_data_out,
   output logic              data_valid_out,
   output logic              err_out,
   output logic [ADDR_W-1:0] bram_addr_out,
   output logic [7:0]        bram_din_out,
   output logic              bram_we_out,
   input  logic [7:0]        bram_dout_in,
   output logic [2:0]        state_dbg_out
);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_WRITE      = 3'd1,
      S_READ_ISSUE = 3'd2,
      S_READ_DRAIN = 3'd3,
      S_DONE       = 3'd4
   } state_t;

   state_t                          state_q, state_d;
   logic [1:0]                      idx_q, idx_d;      // byte index of the current access
   logic [1:0]                      last_q, last_d;    // N-1 for the active request
   logic [31:0]                     wdata_q, wdata_d;
   logic [ADDR_W-1:0]               addr_q, addr_d;
   logic [7:0]                      din_q, din_d;
   logic                            err_q, err_d;
   logic [31:0]                     rbuf_q, rbuf_d;    // load bytes gathered so far
   logic [31:0]                     rdata_q, rdata_d;
   logic [RD_LATENCY-1:0]           pvld_q, pvld_d;    // capture pipe: byte in flight
   logic [RD_LATENCY-1:0][1:0]      pidx_q, pidx_d;    // capture pipe: its byte index

   logic       any_disp;
   logic       bad_req;
   logic       good_req;
   logic       push;
   logic       cap;
   logic [1:0] cap_idx;
   logic [1:0] req_last;
   logic [1:0] next_idx;

   // Upper address bits are deliberately ignored.
   logic unused_addr_hi;
   assign unused_addr_hi = ^addr_in[31:ADDR_W];

   // Next-state, datapath and capture-pipe logic
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      last_d   = last_q;
      wdata_d  = wdata_q;
      addr_d   = addr_q;
      din_d    = din_q;
      err_d    = 1'b0;
      rbuf_d   = rbuf_q;
      rdata_d  = rdata_q;
      pvld_d   = pvld_q;
      pidx_d   = pidx_q;
      push     = 1'b0;
      next_idx = idx_q + 2'd1;

      any_disp = dispatch_read_in | dispatch_write_in;
      bad_req  = any_disp & ((mem_width_in == 2'd3) | (dispatch_read_in & dispatch_write_in));
      good_req = any_disp & ~bad_req;

      case (mem_width_in)
         2'd0:    req_last = 2'd0;
         2'd1:    req_last = 2'd1;
         default: req_last = 2'd3;
      endcase

      // The oldest pipe stage lines up with the BRAM's output byte.
      cap     = pvld_q[RD_LATENCY-1];
      cap_idx = pidx_q[RD_LATENCY-1];
      if (cap) begin
         rbuf_d[{cap_idx, 3'b000} +: 8] = bram_dout_in;
      end

      case (state_q)
         S_IDLE, S_DONE: begin
            // DONE is not busy, so it accepts a new request just like IDLE.
            state_d = S_IDLE;
            if (bad_req) begin
               err_d = 1'b1;
            end else if (good_req) begin
               last_d  = req_last;
               idx_d   = 2'd0;
               addr_d  = addr_in[ADDR_W-1:0];
               wdata_d = write_data_in;
               if (dispatch_write_in) begin
                  din_d   = write_data_in[7:0];
                  state_d = S_WRITE;
               end else begin
                  rbuf_d  = '0;
                  state_d = S_READ_ISSUE;
               end
            end
         end

         S_WRITE: begin
            if (idx_q == last_q) begin
               state_d = S_IDLE;
            end else begin
               idx_d  = next_idx;
               addr_d = addr_q + ADDR_W'(1);
               din_d  = wdata_q[{next_idx, 3'b000} +: 8];
            end
         end

         S_READ_ISSUE: begin
            push = 1'b1;
            if (idx_q == last_q) begin
               state_d = S_READ_DRAIN;
            end else begin
               idx_d  = next_idx;
               addr_d = addr_q + ADDR_W'(1);
            end
         end

         S_READ_DRAIN: begin
            if (cap && (cap_idx == last_q)) begin
               rdata_d = rbuf_d;
               state_d = S_DONE;
            end
         end

         default: state_d = S_IDLE;
      endcase

      // Each address issued enters the pipe tagged with its byte index.
      for (int j = RD_LATENCY - 1; j > 0; j--) begin
         pvld_d[j] = pvld_q[j-1];
         pidx_d[j] = pidx_q[j-1];
      end
      pvld_d[0] = push;
      pidx_d[0] = idx_q;
   end

   // State and datapath registers; reset aborts any request in flight
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         last_q  <= '0;
         wdata_q <= '0;
         addr_q  <= '0;
         din_q   <= '0;
         err_q   <= 1'b0;
         rbuf_q  <= '0;
         rdata_q <= '0;
         pvld_q  <= '0;
         pidx_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         last_q  <= last_d;
         wdata_q <= wdata_d;
         addr_q  <= addr_d;
         din_q   <= din_d;
         err_q   <= err_d;
         rbuf_q  <= rbuf_d;
         rdata_q <= rdata_d;
         pvld_q  <= pvld_d;
         pidx_q  <= pidx_d;
      end
   end

   assign busy_out       = (state_q == S_WRITE) || (state_q == S_READ_ISSUE) ||
                           (state_q == S_READ_DRAIN);
   assign bram_we_out    = (state_q == S_WRITE);
   assign data_valid_out = (state_q == S_DONE);
   assign err_out        = err_q;
   assign read_data_out  = rdata_q;
   assign bram_addr_out  = addr_q;
   assign bram_din_out   = din_q;
   assign state_dbg_out  = state_q;

endmodule
